pattern_gen_tx: RTL and testbench
=================================

Name: pattern_gen_tx

Overview:
Transmit-side test-pattern source for the equality-checking datapath. Generates a deterministic word stream (PRBS-7, counter, fixed, walking-ones) over a valid/ready interface. The downstream checker regenerates the same sequence and compares it word-for-word. Supports a bounded or continuous run and single-word error injection for checker self-test.

Parameters:
WIDTH, 8, data word width in bits (2..32)
CNT_W, 16, width of word-count input/output

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run when not busy
stop  input  1  one-cycle pulse; aborts current run
mode  input  2  pattern select: 0 PRBS-7, 1 counter, 2 fixed, 3 walking-ones; sampled on start
seed  input  7  PRBS-7 initial LFSR state; sampled on start; 0 treated as 7'h7F
fixed_pat  input  WIDTH  word for mode 2; sampled on start
num_words  input  CNT_W  words per run; 0 = continuous; sampled on start
inject_err  input  1  pulse; corrupt next accepted word
out_data  output  WIDTH  current word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts when high with out_valid
busy  output  1  run in progress
done  output  1  bounded run completed
word_cnt  output  CNT_W  words accepted in current/last run

Behaviour:
- Reset (async, rst_n low): state IDLE; out_data 0, out_valid 0, busy 0, done 0, word_cnt 0, LFSR 7'h7F, inject pending cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start: latch mode/seed/fixed_pat/num_words, word_cnt<=0, done<=0, compute first word. Enter RUN. out_valid=1 and busy=1 on the next cycle, so latency is 1 clock from start.
- RUN: out_data is held stable while out_valid && !out_ready. On accept (out_valid && out_ready): word_cnt+1, next word presented on the next cycle with no bubble.
- Bounded run: the accept that brings word_cnt to num_words moves to DONE. out_valid=0, busy=0, done=1 (level, held until next start or reset).
- Continuous (num_words=0): never self-terminates. word_cnt wraps 2^CNT_W-1 -> 0 with no other effect.
- stop in RUN: next cycle IDLE, out_valid=0, busy=0, done=0. A word pending but not accepted is dropped, and word_cnt keeps the accepted count. If stop and an accept occur in the same cycle, the accept counts and stop still wins. stop in IDLE/DONE is ignored.
- start while RUN is ignored. start and stop in the same cycle in RUN: stop wins. In IDLE: start wins.
- PRBS-7 (x^7+x^6+1): per bit, new=lfsr[6]^lfsr[5], lfsr<={lfsr[5:0],new}. A word is WIDTH successive new bits, MSB first, so the LFSR advances WIDTH steps per accepted word (unrolled combinationally).
- Counter: 0,1,2,...; wraps at 2^WIDTH-1 -> 0.
- Fixed: fixed_pat every word.
- Walking-ones: 1<<0, 1<<1, ..., 1<<(WIDTH-1), then back to 1<<0.
- Error injection: inject_err sets a sticky pending flag. While pending, out_data bit 0 is inverted on the presented word. The flag clears on that word's accept. Pattern state (LFSR/counter) is never affected. Pending is cleared on start, stop, and reset. A pulse outside RUN is ignored.
- Reset mid-run: immediate return to reset values; no partial word is reported.

Test Plan:
- WIDTH=8, mode 0, seed 0x7F, num_words 2, out_ready=1 -> out_data 0x02 then 0x0C on consecutive cycles; done=1, word_cnt=2, out_valid=0 after the second accept.
- mode 1, num_words 5, out_ready toggled 1,0,0,1,... -> values 0..4 each held stable while ready low; exactly 5 accepts; done asserted.
- mode 3, num_words 10 -> 0x01,0x02,...,0x80,0x01,0x02; done asserted.
- mode 2, fixed_pat 0xA5, num_words 0, inject_err pulsed during word 3 -> words 0xA5 except one 0xA4; the following word is 0xA5; stream continues until stop; out_valid low the cycle after stop.
- mode 0, seed 0 -> identical to seed 0x7F. Assert rst_n low mid-run with out_ready=0 -> all outputs 0 asynchronously. A new start replays the sequence from 0x02.
- start pulsed during RUN and start+stop in the same cycle -> run unaffected / run aborted respectively; word_cnt unchanged by the ignored start.

Source files
------------

// File: rtl/pattern_gen_tx.sv
// Test-pattern source: PRBS-7 / counter / fixed / walking-ones words over valid/ready,
// with bounded or continuous runs and single-word bit-0 error injection.
module pattern_gen_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [6:0]       seed,
  input  logic [WIDTH-1:0] fixed_pat,
  input  logic [CNT_W-1:0] num_words,
  input  logic             inject_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] fixed_r;
  logic [CNT_W-1:0] num_r;
  logic [6:0]       lfsr;
  logic [WIDTH-1:0] word_q;
  logic             inj_pend;

  // WIDTH LFSR steps unrolled; returns {advanced_lfsr, word} with the first new bit as MSB.
  function automatic logic [WIDTH+6:0] prbs_word(input logic [6:0] s);
    logic [6:0]       l;
    logic [WIDTH-1:0] w;
    logic             b;
    l = s;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      b = l[6] ^ l[5];
      l = {l[5:0], b};
      w = {w[WIDTH-2:0], b};
    end
    return {l, w};
  endfunction

  logic [6:0]       seed_eff;
  logic [WIDTH+6:0] prbs_first, prbs_next;
  logic [WIDTH-1:0] first_word, next_word;
  logic             go, abort, accept, last;

  assign seed_eff   = (seed == 7'd0) ? 7'h7F : seed;
  assign prbs_first = prbs_word(seed_eff);
  assign prbs_next  = prbs_word(lfsr);
  assign go         = (state != RUN) && start;
  assign abort      = (state == RUN) && stop;
  assign accept     = out_valid && out_ready;
  assign last       = (num_r != '0) && ((word_cnt + CNT_W'(1)) == num_r);

  always_comb begin
    first_word = '0;
    case (mode)
      2'd0: first_word = prbs_first[WIDTH-1:0];
      2'd1: first_word = '0;
      2'd2: first_word = fixed_pat;
      2'd3: first_word = WIDTH'(1);
    endcase
  end

  always_comb begin
    next_word = word_q;
    case (mode_r)
      2'd0: next_word = prbs_next[WIDTH-1:0];
      2'd1: next_word = word_q + WIDTH'(1);
      2'd2: next_word = fixed_r;
      2'd3: next_word = {word_q[WIDTH-2:0], word_q[WIDTH-1]};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; stop beats a same-cycle final accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (stop)                state_nxt = IDLE;
        else if (accept && last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; data is masked to zero whenever nothing is presented
  always_comb begin
    out_valid = (state == RUN);
    busy      = (state == RUN);
    done      = (state == DONE);
    out_data  = (state == RUN) ? (word_q ^ {{(WIDTH-1){1'b0}}, inj_pend}) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r   <= 2'd0;
      fixed_r  <= '0;
      num_r    <= '0;
      lfsr     <= 7'h7F;
      word_q   <= '0;
      word_cnt <= '0;
    end else if (go) begin
      mode_r   <= mode;
      fixed_r  <= fixed_pat;
      num_r    <= num_words;
      lfsr     <= prbs_first[WIDTH+6:WIDTH];
      word_q   <= first_word;
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + CNT_W'(1);
      word_q   <= next_word;
      if (mode_r == 2'd0) lfsr <= prbs_next[WIDTH+6:WIDTH];
    end
  end

  // A new inject request outranks clearing by the accept of the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           inj_pend <= 1'b0;
    else if (go || abort)                 inj_pend <= 1'b0;
    else if (state == RUN && inject_err)  inj_pend <= 1'b1;
    else if (accept)                      inj_pend <= 1'b0;
  end

endmodule

// File: tb/tb_pattern_gen_tx.sv
// Randomised + directed bench for pattern_gen_tx against a word-level reference model.
module tb_pattern_gen_tx;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk, rst_n, start, stop, inject_err, out_ready;
  logic [1:0]       mode;
  logic [6:0]       seed;
  logic [WIDTH-1:0] fixed_pat, out_data;
  logic [CNT_W-1:0] num_words, word_cnt;
  logic             out_valid, busy, done;

  pattern_gen_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .seed(seed),
    .fixed_pat(fixed_pat), .num_words(num_words), .inject_err(inject_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .word_cnt(word_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run/done flags, accepted count, current word.
  logic       m_run, m_done, m_pend;
  int         m_cnt, m_num, m_mode, m_idx;
  logic [7:0] m_fixed;
  int         m_word;
  logic [6:0] m_lfsr;

  task automatic m_reset();
    m_run = 0; m_done = 0; m_pend = 0; m_cnt = 0; m_word = 0; m_lfsr = 7'h7F;
  endtask

  task automatic m_prbs();
    logic b;
    m_word = 0;
    for (int i = 0; i < WIDTH; i++) begin
      b = m_lfsr[6] ^ m_lfsr[5];
      m_lfsr = {m_lfsr[5:0], b};
      m_word = m_word * 2 + int'(b);
    end
  endtask

  task automatic m_advance();
    case (m_mode)
      0: m_prbs();
      1: m_word = (m_word + 1) % 256;
      2: m_word = int'(m_fixed);
      default: begin m_idx = (m_idx + 1) % WIDTH; m_word = 1 << m_idx; end
    endcase
  endtask

  task automatic model_step();
    bit acc;
    if (!m_run) begin
      if (start) begin
        m_mode = int'(mode); m_fixed = fixed_pat; m_num = int'(num_words);
        m_cnt = 0; m_done = 0; m_pend = 0; m_run = 1;
        m_lfsr = (seed == 0) ? 7'h7F : seed;
        m_idx = 0;
        case (m_mode)
          0: m_prbs();
          1: m_word = 0;
          2: m_word = int'(fixed_pat);
          default: m_word = 1;
        endcase
      end
    end else begin
      acc = out_ready;
      if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (stop) begin
        m_run = 0; m_pend = 0;
      end else begin
        if (inject_err) m_pend = 1;
        else if (acc)   m_pend = 0;
        if (acc) begin
          if (m_num != 0 && m_cnt == m_num) begin m_run = 0; m_done = 1; end
          else m_advance();
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(m_run));
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("word_cnt", int'(word_cnt), m_cnt);
      if (m_run) chk("out_data", int'(out_data), m_word ^ int'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    start = 0; stop = 0; inject_err = 0;
  endtask

  logic [7:0] cap[$];

  task automatic launch(input int md, input int sd, input int fp, input int nw);
    mode = 2'(md); seed = 7'(sd); fixed_pat = 8'(fp); num_words = 4'(nw);
    start = 1;
    tick();
    cap.delete();
  endtask

  // Ready pattern: period p, high on phase 0 only (p=1 means always ready).
  task automatic run_to_done(input int p, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      out_ready = (i % p == 0);
      if (out_valid && out_ready) cap.push_back(out_data);
      tick();
      i++;
    end
    if (!done) begin n_cmp++; n_bad++; $display("FAIL run_to_done: timeout done=%0d", done); end
  endtask

  int a4_idx, cnt_before;

  initial begin
    rst_n = 0; start = 0; stop = 0; inject_err = 0; out_ready = 0;
    mode = 0; seed = 0; fixed_pat = 0; num_words = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst word_cnt", int'(word_cnt), 0);
    chk("rst out_data", int'(out_data), 0);
    rst_n = 1;
    chk_en = 1;

    // PRBS-7 from 0x7F, two words
    launch(0, 7'h7F, 0, 2);
    run_to_done(1, 20);
    chk("prbs n", cap.size(), 2);
    if (cap.size() == 2) begin chk("prbs w0", int'(cap[0]), 8'h02); chk("prbs w1", int'(cap[1]), 8'h0C); end
    chk("prbs done", int'(done), 1);
    chk("prbs cnt", int'(word_cnt), 2);
    chk("prbs valid", int'(out_valid), 0);

    // counter with backpressure
    launch(1, 0, 0, 5);
    run_to_done(3, 60);
    chk("ctr n", cap.size(), 5);
    foreach (cap[k]) chk("ctr word", int'(cap[k]), k);

    // walking ones, 10 words
    launch(3, 0, 0, 10);
    run_to_done(1, 40);
    chk("walk n", cap.size(), 10);
    if (cap.size() == 10) begin
      chk("walk w7", int'(cap[7]), 8'h80);
      chk("walk w8", int'(cap[8]), 8'h01);
      chk("walk w9", int'(cap[9]), 8'h02);
    end

    // fixed continuous with an injected error on the word after word 3
    launch(2, 0, 8'hA5, 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) cap.push_back(out_data);
      inject_err = (i == 3);
      tick();
    end
    a4_idx = -1;
    foreach (cap[k]) if (cap[k] == 8'hA4) a4_idx = k;
    chk("inj pos", a4_idx, 4);
    chk("inj next", int'(cap[5]), 8'hA5);
    stop = 1;
    tick();
    chk("stop valid", int'(out_valid), 0);
    chk("stop done", int'(done), 0);

    // seed 0 acts as 0x7F; async reset mid-run with ready low
    launch(0, 0, 0, 0);
    chk("seed0 w0", int'(out_data), 8'h02);
    out_ready = 1; tick(); tick();
    out_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("arst valid", int'(out_valid), 0);
    chk("arst busy", int'(busy), 0);
    chk("arst data", int'(out_data), 0);
    chk("arst cnt", int'(word_cnt), 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    launch(0, 7'h7F, 0, 0);
    chk("replay w0", int'(out_data), 8'h02);
    stop = 1; tick();

    // ignored start during a run, then start+stop aborts
    launch(1, 0, 0, 0);
    out_ready = 1; tick(); tick(); tick();
    cnt_before = int'(word_cnt);
    mode = 2; start = 1; tick();
    chk("ign start cnt", int'(word_cnt), cnt_before + 1);
    chk("ign start data", int'(out_data), 4);
    start = 1; stop = 1; tick();
    chk("start+stop valid", int'(out_valid), 0);
    chk("start+stop done", int'(done), 0);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom % 10) == 0;
      stop       = ($urandom % 30) == 0;
      inject_err = ($urandom % 8) == 0;
      out_ready  = ($urandom % 4) != 0;
      mode       = 2'($urandom);
      seed       = (($urandom % 4) == 0) ? 7'd0 : 7'($urandom);
      fixed_pat  = 8'($urandom);
      num_words  = 4'($urandom % 13);
      tick();
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
